// File: rtl/niu_pkg.sv
// Shared NIU definitions: arbiter state encoding, datapath width and the
// round-robin pick helper used by the TX arbiter and the RX distributor.
package niu_pkg;

    localparam int NIU_DATA_W  = 64;
    localparam int NIU_MAX_SRC = 8;

    typedef enum logic [1:0] {IDLE, XFER, GAP} arb_state_e;

    // First set bit of req at or above ptr, wrapping within num entries.
    function automatic logic [2:0] rr_pick(input logic [NIU_MAX_SRC-1:0] req,
                                           input logic [2:0]             ptr,
                                           input int unsigned            num);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NIU_MAX_SRC; k++) begin
            idx = (32'(ptr) + k) % num;
            if (k < num && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/niu_rr_picker.sv
// Combinational round-robin priority encoder: request vector plus pointer
// in, winning index and any-request flag out.
module niu_rr_picker
    import niu_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int GW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               any
);

    logic [NIU_MAX_SRC-1:0] req_ext;
    logic [2:0]             ptr_ext;
    logic [2:0]             win;

    always_comb begin
        req_ext = NIU_MAX_SRC'(req);
        ptr_ext = 3'(ptr);
        win     = rr_pick(req_ext, ptr_ext, NUM_SRC);
    end

    assign winner = GW'(win);
    assign any    = |req;

endmodule

// File: rtl/niu_tx_arbiter.sv
// Packet-level round-robin arbiter onto the XGMII TX stream with a minimum
// inter-frame gap. Define NIU_TXARB_STATS_EN for frame/error counters.
module niu_tx_arbiter
    import niu_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = NIU_DATA_W,
    parameter  int MIN_IPG = 2,
    localparam int GW      = $clog2(NUM_SRC),
    localparam int KW      = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arb_en,
    input  logic [NUM_SRC-1:0]    s_valid,
    output logic [NUM_SRC-1:0]    s_ready,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC*KW-1:0] s_keep,
    input  logic [NUM_SRC-1:0]    s_sop,
    input  logic [NUM_SRC-1:0]    s_eop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [KW-1:0]         m_keep,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  sop_err
`ifdef NIU_TXARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0] frame_cnt,
    output logic [31:0]           err_cnt
`endif
);

    arb_state_e         state;
    logic [GW-1:0]      rr_ptr;
    logic [3:0]         gap_cnt;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] stray;
    logic [GW-1:0]      winner;
    logic               any_cand;
    logic               hs_eop;
    logic               stray_hit;
    logic [GW-1:0]      next_ptr;

    assign cand      = s_valid & s_sop;
    assign stray     = s_valid & ~s_sop;
    assign stray_hit = (state == IDLE) && (|stray);
    assign busy      = (state == XFER);
    assign hs_eop    = (state == XFER) && m_valid && m_ready && m_eop;
    assign next_ptr  = (grant_id == GW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

    niu_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .GW      (GW)
    ) u_picker (
        .req    (cand),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_cand)
    );

    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        s_ready = '0;
        if (state == XFER) begin
            m_valid           = s_valid[grant_id];
            m_data            = s_data[32'(grant_id)*DATA_W +: DATA_W];
            m_keep            = s_keep[32'(grant_id)*KW +: KW];
            m_sop             = s_sop[grant_id];
            m_eop             = s_eop[grant_id];
            s_ready[grant_id] = m_ready;
        end else if (state == IDLE) begin
            // Stray mid-frame beats are drained so a source cannot wedge IDLE.
            s_ready = stray;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
            sop_err  <= 1'b0;
        end else begin
            sop_err <= stray_hit;
            case (state)
                IDLE: begin
                    if (arb_en && any_cand) begin
                        grant_id <= winner;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (hs_eop) begin
                        rr_ptr <= next_ptr;
                        if (MIN_IPG > 0) begin
                            state   <= GAP;
                            gap_cnt <= 4'(MIN_IPG - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NIU_TXARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (hs_eop && grant_id == GW'(i))
                    frame_cnt[i*32 +: 32] <= frame_cnt[i*32 +: 32] + 32'd1;
            end
            if (stray_hit) err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule
